// File: rtl/external_bus_responder.sv
// Memory-side responder for the core's byte-wide external interface: services one
// transaction at a time, answers the reset vector locally and aborts stalled accesses.
module external_bus_responder #(
   parameter logic [15:0] RESET_VECTOR = 16'hAABB,
   parameter int unsigned WAIT_STATES  = 0,
   parameter int unsigned TIMEOUT      = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic        cpu_rw,
   input  logic [7:0]  cpu_addr_low,
   input  logic [7:0]  cpu_addr_high,
   input  logic [7:0]  cpu_data_write,
   output logic [7:0]  cpu_data_read,
   output logic        cpu_ready,
   output logic        cpu_done,
   output logic        bus_error,
   input  logic        error_clear,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {StIdle, StIssue, StHold, StResp} state_e;

   localparam logic [7:0] WaitLoad    = 8'(WAIT_STATES);
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        rw_q, rw_d;
   logic        err_q, err_d;
   logic [15:0] req_addr;
   logic        is_vector;

   assign req_addr  = {cpu_addr_high, cpu_addr_low};
   // FFFC and FFFD share every bit but bit 0; only reads are intercepted.
   assign is_vector = cpu_rw && (req_addr[15:1] == 15'h7FFE);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rw_d    = rw_q;
      err_d   = err_q;
      if (error_clear) begin
         err_d = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (cpu_req) begin
               addr_d  = req_addr;
               wdata_d = cpu_data_write;
               rw_d    = cpu_rw;
               cnt_d   = 8'd0;
               if (is_vector) begin
                  rdata_d = cpu_addr_low[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
                  state_d = StResp;
               end else begin
                  state_d = StIssue;
               end
            end
         end
         StIssue: begin
            // An ack on the final allowed cycle beats the timeout.
            if (mem_ack) begin
               if (rw_q) begin
                  rdata_d = mem_rdata;
               end
               if (WAIT_STATES != 0) begin
                  cnt_d   = WaitLoad;
                  state_d = StHold;
               end else begin
                  state_d = StResp;
               end
            end else if (cnt_q == TimeoutLast) begin
               err_d   = 1'b1;
               if (rw_q) begin
                  rdata_d = 8'hFF;
               end
               state_d = StResp;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StHold: begin
            if (cnt_q <= 8'd1) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rw_q    <= rw_d;
         err_q   <= err_d;
      end
   end

   assign cpu_ready     = (state_q == StIdle);
   assign cpu_done      = (state_q == StResp);
   assign mem_re        = (state_q == StIssue) &&  rw_q;
   assign mem_we        = (state_q == StIssue) && !rw_q;
   assign cpu_data_read = rdata_q;
   assign bus_error     = err_q;
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;

endmodule

// File: tb/tb_external_bus_responder.sv
// Randomized bench for external_bus_responder: two instances (no wait states and two
// wait states) checked against a transaction-level latency/data model.
module tb_external_bus_responder;

   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        req       [2];
   logic        rw_s      [2];
   logic [7:0]  alo       [2];
   logic [7:0]  ahi       [2];
   logic [7:0]  wdat      [2];
   logic [7:0]  rdat_o    [2];
   logic        ready     [2];
   logic        done      [2];
   logic        berr      [2];
   logic        eclr      [2];
   logic [15:0] maddr     [2];
   logic [7:0]  mwdata    [2];
   logic        mre       [2];
   logic        mwe       [2];
   logic [7:0]  mrdata    [2];
   logic        mack      [2];

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [7:0]  model_rdata [2];
   logic        model_err   [2];
   logic [15:0] rv = 16'hAABB;

   always #5 clk = ~clk;

   external_bus_responder #(.RESET_VECTOR(16'hAABB), .WAIT_STATES(0), .TIMEOUT(TO)) u_dut0 (
      .clk(clk), .rst(rst[0]), .cpu_req(req[0]), .cpu_rw(rw_s[0]), .cpu_addr_low(alo[0]),
      .cpu_addr_high(ahi[0]), .cpu_data_write(wdat[0]), .cpu_data_read(rdat_o[0]),
      .cpu_ready(ready[0]), .cpu_done(done[0]), .bus_error(berr[0]), .error_clear(eclr[0]),
      .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_re(mre[0]), .mem_we(mwe[0]),
      .mem_rdata(mrdata[0]), .mem_ack(mack[0])
   );

   external_bus_responder #(.RESET_VECTOR(16'hAABB), .WAIT_STATES(2), .TIMEOUT(TO)) u_dut1 (
      .clk(clk), .rst(rst[1]), .cpu_req(req[1]), .cpu_rw(rw_s[1]), .cpu_addr_low(alo[1]),
      .cpu_addr_high(ahi[1]), .cpu_data_write(wdat[1]), .cpu_data_read(rdat_o[1]),
      .cpu_ready(ready[1]), .cpu_done(done[1]), .bus_error(berr[1]), .error_clear(eclr[1]),
      .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_re(mre[1]), .mem_we(mwe[1]),
      .mem_rdata(mrdata[1]), .mem_ack(mack[1])
   );

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      check({tag, "/rdata"}, 32'(rdat_o[d]), 32'h00);
      check({tag, "/done"}, 32'(done[d]), 32'd0);
      check({tag, "/berr"}, 32'(berr[d]), 32'd0);
      check({tag, "/maddr"}, 32'(maddr[d]), 32'h0000);
      check({tag, "/mwdata"}, 32'(mwdata[d]), 32'h00);
      check({tag, "/mreq"}, 32'({mre[d], mwe[d]}), 32'd0);
      check({tag, "/ready"}, 32'(ready[d]), 32'd1);
   endtask

   // Called at a negedge; applies reset for one rising edge.
   task automatic do_reset(input int d);
      rst[d] = 1'b1;
      @(negedge clk);
      rst[d] = 1'b0;
      model_rdata[d] = 8'h00;
      model_err[d]   = 1'b0;
   endtask

   // One complete transaction. ack_wait = ISSUE cycles before ack (>= TO means never).
   task automatic run_txn(input string tag, input int d, input logic rw, input logic [15:0] addr,
                          input logic [7:0] wd, input int ack_wait, input logic [7:0] rd,
                          input logic hold_req, input logic clr_during);
      logic       vec;
      int         exp_lat, exp_issue, lat, n_issue, bad_strobe, ready_hi;
      logic [7:0] exp_data;
      logic       exp_err;
      vec = rw && (addr == 16'hFFFC || addr == 16'hFFFD);
      exp_err = clr_during ? 1'b0 : model_err[d];
      if (vec) begin
         exp_lat   = 1;
         exp_issue = 0;
         exp_data  = addr[0] ? rv[15:8] : rv[7:0];
         exp_err   = model_err[d];
      end else if (ack_wait < TO) begin
         exp_lat   = 2 + ack_wait + ws_of(d);
         exp_issue = ack_wait + 1;
         exp_data  = rw ? rd : model_rdata[d];
      end else begin
         exp_lat   = 1 + TO;
         exp_issue = TO;
         exp_data  = rw ? 8'hFF : model_rdata[d];
         exp_err   = 1'b1;
      end

      check({tag, "/idle_ready"}, 32'(ready[d]), 32'd1);
      req[d]  = 1'b1;
      rw_s[d] = rw;
      alo[d]  = addr[7:0];
      ahi[d]  = addr[15:8];
      wdat[d] = wd;
      @(posedge clk);
      lat = -1; n_issue = 0; bad_strobe = 0; ready_hi = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (!hold_req) req[d] = 1'b0;
         if (done[d]) begin
            lat = c;
            break;
         end
         if (ready[d]) ready_hi++;
         if (mre[d] || mwe[d]) begin
            n_issue++;
            if (mre[d] !== rw || mwe[d] !== !rw || maddr[d] !== addr || mwdata[d] !== wd)
               bad_strobe++;
            mack[d]   = (n_issue - 1 == ack_wait);
            mrdata[d] = mack[d] ? rd : 8'($urandom);
         end else begin
            // Acks outside ISSUE must have no effect.
            mack[d]   = 1'($urandom_range(0, 1));
            mrdata[d] = 8'($urandom);
         end
         eclr[d] = clr_during;
      end
      req[d] = 1'b0; mack[d] = 1'b0; eclr[d] = 1'b0;
      check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "/rdata"}, 32'(rdat_o[d]), 32'(exp_data));
      check({tag, "/berr"}, 32'(berr[d]), 32'(exp_err));
      check({tag, "/issue_cycles"}, 32'(n_issue), 32'(exp_issue));
      check({tag, "/bad_strobe"}, 32'(bad_strobe), 32'd0);
      check({tag, "/ready_while_busy"}, 32'(ready_hi), 32'd0);
      model_rdata[d] = exp_data;
      model_err[d]   = exp_err;
      @(negedge clk);
      check({tag, "/post_done"}, 32'(done[d]), 32'd0);
      check({tag, "/post_ready"}, 32'(ready[d]), 32'd1);
      check({tag, "/post_mreq"}, 32'({mre[d], mwe[d]}), 32'd0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; rw_s[d] = 1'b0; alo[d] = 8'h00; ahi[d] = 8'h00;
         wdat[d] = 8'h00; eclr[d] = 1'b0; mrdata[d] = 8'h00; mack[d] = 1'b0;
         model_rdata[d] = 8'h00; model_err[d] = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      check_reset_outputs(0, "reset0");
      check_reset_outputs(1, "reset1");

      run_txn("vec_lo", 0, 1'b1, 16'hFFFC, 8'h00, 0, 8'h00, 1'b0, 1'b0);
      run_txn("vec_hi", 0, 1'b1, 16'hFFFD, 8'h00, 0, 8'h00, 1'b0, 1'b0);
      run_txn("vec_lo_ws", 1, 1'b1, 16'hFFFC, 8'h00, 0, 8'h00, 1'b0, 1'b0);
      run_txn("wr_0200", 0, 1'b0, 16'h0200, 8'h5A, 0, 8'h00, 1'b0, 1'b0);
      run_txn("wr_fffc", 0, 1'b0, 16'hFFFC, 8'h11, 1, 8'h00, 1'b0, 1'b0);
      run_txn("rd_1234_ws2", 1, 1'b1, 16'h1234, 8'h00, 2, 8'hC3, 1'b1, 1'b0);
      run_txn("rd_timeout", 0, 1'b1, 16'h3000, 8'h00, 255, 8'h00, 1'b0, 1'b0);
      eclr[0] = 1'b1;
      @(negedge clk);
      eclr[0] = 1'b0;
      model_err[0] = 1'b0;
      check("err_clear", 32'(berr[0]), 32'd0);
      run_txn("ack_at_limit", 0, 1'b1, 16'h3001, 8'h00, TO - 1, 8'h77, 1'b0, 1'b0);
      run_txn("to_vs_clear", 1, 1'b0, 16'h4000, 8'h99, 255, 8'h00, 1'b0, 1'b1);

      // Reset in the middle of an ISSUE phase.
      req[0] = 1'b1; rw_s[0] = 1'b1; alo[0] = 8'h00; ahi[0] = 8'h50; wdat[0] = 8'h00;
      @(negedge clk);
      req[0] = 1'b0;
      @(negedge clk);
      check("mid_rst/pre_re", 32'(mre[0]), 32'd1);
      do_reset(0);
      check_reset_outputs(0, "mid_rst");
      mack[0] = 1'b1; mrdata[0] = 8'hE7;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("mid_rst/late_ack", 32'({done[0], mre[0], ready[0], rdat_o[0]}), 32'h100);
      end
      mack[0] = 1'b0;

      for (int i = 0; i < 40; i++) begin
         int          d, sel, r;
         logic        rw;
         logic [15:0] addr;
         d    = int'($urandom_range(0, 1));
         rw   = 1'($urandom_range(0, 1));
         sel  = int'($urandom_range(0, 7));
         addr = (sel == 0) ? 16'hFFFC : (sel == 1) ? 16'hFFFD : 16'($urandom);
         r    = int'($urandom_range(0, 9));
         run_txn($sformatf("rand%0d", i), d, rw, addr, 8'($urandom),
                 (r == 0) ? 255 : int'($urandom_range(0, 5)), 8'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/external_bus_responder.md
Name: external_bus_responder

Overview:
- Memory-side counterpart of the CPU dataflow's external interface.
- Accepts one byte transaction at a time from the core (address low/high bytes, write data, read/write flag) and services it against a handshaked memory port.
- Returns read data plus a done pulse, and drives a ready/stall signal back to the control logic.
- Answers the reset-vector bytes locally and converts unanswered memory accesses into a bus error.

Parameters:
- RESET_VECTOR, 16'hAABB, value returned for reads of 16'hFFFC (low byte) and 16'hFFFD (high byte).
- WAIT_STATES, 0, extra hold cycles inserted after mem_ack before responding (0..15).
- TIMEOUT, 15, cycles in ISSUE without mem_ack before abort (1..255).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  transaction strobe; sampled only when cpu_ready=1.
- cpu_rw  input  1  1=read, 0=write.
- cpu_addr_low  input  8  address bits 7:0.
- cpu_addr_high  input  8  address bits 15:8.
- cpu_data_write  input  8  write data.
- cpu_data_read  output  8  read data; held until the next read completes.
- cpu_ready  output  1  1 only in IDLE; the core must stall while 0.
- cpu_done  output  1  one-cycle pulse in RESP.
- bus_error  output  1  sticky abort flag.
- error_clear  input  1  clears bus_error.
- mem_addr  output  16  latched address.
- mem_wdata  output  8  latched write data.
- mem_re  output  1  read request, held high through ISSUE for reads.
- mem_we  output  1  write request, held high through ISSUE for writes.
- mem_rdata  input  8  memory read data, valid with mem_ack.
- mem_ack  input  1  memory completion; ignored outside ISSUE.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: state=IDLE; cpu_data_read=8'h00, cpu_done=0, bus_error=0, mem_addr=16'h0000, mem_wdata=8'h00, mem_re=0, mem_we=0; wait and timeout counters cleared. cpu_ready=1 from the first clock after reset.
- Reset mid-transaction: the transaction is abandoned. mem_re/mem_we drop on that edge and no cpu_done is issued.
- States: IDLE, ISSUE, HOLD, RESP.
- IDLE:
  - cpu_ready=1; mem_re=mem_we=0.
  - On cpu_req=1: latch {addr_high,addr_low} into mem_addr, cpu_data_write into mem_wdata, and cpu_rw.
  - Read of 16'hFFFC or 16'hFFFD → RESP directly. cpu_data_read is loaded with the matching RESET_VECTOR byte on that edge.
  - Anything else → ISSUE with the timeout counter cleared.
  - Writes to FFFC/FFFD are not intercepted; they go to memory.
- ISSUE:
  - mem_re=cpu_rw, mem_we=~cpu_rw; cpu_ready=0.
  - On mem_ack=1: for reads, capture mem_rdata into cpu_data_read. Then go to HOLD if WAIT_STATES>0 (counter loaded with WAIT_STATES), else RESP.
  - If there is no ack, increment the timeout counter. When it reaches TIMEOUT (i.e. TIMEOUT cycles without ack): set bus_error=1, load cpu_data_read=8'hFF for reads (unchanged for writes), go to RESP.
  - An ack arriving on the same cycle the count reaches TIMEOUT wins; no error is raised.
- HOLD: requests deasserted. Decrement the counter; go to RESP when it reaches 1.
- RESP: cpu_done=1 for exactly one cycle → IDLE.
- Latencies (accept edge = T):
  - Vector read: done at T+1.
  - Memory access with ack in its first ISSUE cycle and WAIT_STATES=0: done at T+2.
  - Each extra ack-wait or wait-state cycle adds 1.
  - Back-to-back transactions: a new request is accepted in the cycle after RESP, so the minimum spacing is 3 cycles for memory accesses.
- cpu_req outside IDLE is ignored; it is not queued.
- mem_ack outside ISSUE is ignored.
- bus_error:
  - Set by timeout.
  - Cleared by rst or error_clear.
  - If a timeout and error_clear occur in the same cycle, set wins.
  - Does not block later transactions.
- mem_addr and mem_wdata are stable from ISSUE entry until the next accept.

Test Plan:
- Reset then read of FFFC and FFFD with RESET_VECTOR=16'hAABB → cpu_data_read=8'hBB, then 8'hAA; cpu_done at T+1 each; mem_re never asserted.
- Write 8'h5A to 16'h0200, mem_ack on the first ISSUE cycle → mem_we=1, mem_addr=16'h0200, mem_wdata=8'h5A for one cycle; cpu_done at T+2; cpu_ready low at T+1 and T+2.
- Read 16'h1234 with WAIT_STATES=2, mem_ack after 3 ISSUE cycles returning 8'hC3 → cpu_data_read=8'hC3; cpu_done at T+6; a cpu_req held high during the transaction is not serviced twice.
- Read with mem_ack never asserted, TIMEOUT=15 → after 15 ISSUE cycles cpu_data_read=8'hFF and bus_error=1; cpu_done fires; error_clear pulse → bus_error=0.
- Mid-ISSUE rst pulse → mem_re=0 after the edge, no cpu_done, cpu_ready=1, all outputs at reset values; a later mem_ack is ignored.
